// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU controller: FSM states, register file geometry, opcodes.
package alu_ctrl_pkg;

    localparam int REG_W = 16;
    localparam int NREG  = 8;
    localparam int IDX_W = 3;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Last ISSUE count value before giving up: counts 0..14 cover fifteen cycles.
    localparam logic [3:0] TMO_LAST = 4'd14;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WB    = 2'd2
    } state_t;

endpackage

// File: rtl/alu_ctrl_regfile.sv
// 8x16 general-purpose register file: two combinational read ports, one write port, async clear.
module alu_ctrl_regfile
    import alu_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [REG_W-1:0] wdata,
    input  logic [IDX_W-1:0] raddr_a,
    output logic [REG_W-1:0] rdata_a,
    input  logic [IDX_W-1:0] raddr_b,
    output logic [REG_W-1:0] rdata_b
);

    logic [REG_W-1:0] regs [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = regs[raddr_a];
    assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/alu_ctrl.sv
// Issues ADD/SUB instructions to an external ALU and writes the result back to the register file.
// Optional ALU_CTRL_TIMEOUT_EN adds a 15-cycle ISSUE timeout with a sticky err output.
module alu_ctrl
    import alu_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic             instr_op,
    input  logic [IDX_W-1:0] instr_rd,
    input  logic [IDX_W-1:0] instr_ra,
    input  logic [IDX_W-1:0] instr_rb,
    input  logic             ld_en,
    input  logic [IDX_W-1:0] ld_addr,
    input  logic [REG_W-1:0] ld_data,
    output logic             in_alu,
    output logic             operation,
    output logic [REG_W-1:0] operand1,
    output logic [REG_W-1:0] operand2,
    input  logic [REG_W-1:0] result,
    input  logic             out_alu,
    output logic             done,
    output logic [IDX_W-1:0] wb_addr,
    output logic [REG_W-1:0] wb_data
`ifdef ALU_CTRL_TIMEOUT_EN
    ,
    output logic             err
`endif
);

    state_t           state;
    logic [IDX_W-1:0] rd_q;
    logic             out_alu_q;
    logic             accept;
    logic             complete;
    logic             rf_we;
    logic [IDX_W-1:0] rf_waddr;
    logic [REG_W-1:0] rf_wdata;
    logic [REG_W-1:0] ra_data;
    logic [REG_W-1:0] rb_data;
`ifdef ALU_CTRL_TIMEOUT_EN
    logic [3:0]       tmo_cnt;
`endif

    assign instr_ready = (state == IDLE) && !ld_en;
    assign accept      = instr_valid && instr_ready;
    // Only a rising out_alu counts, so a level left high by the previous operation is ignored.
    assign complete    = (state == ISSUE) && out_alu && !out_alu_q;

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = ld_addr;
        rf_wdata = ld_data;
        if (state == WB) begin
            rf_we    = 1'b1;
            rf_waddr = rd_q;
            rf_wdata = wb_data;
        end else if ((state == IDLE) && ld_en) begin
            rf_we = 1'b1;
        end
    end

    alu_ctrl_regfile u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (rf_we),
        .waddr   (rf_waddr),
        .wdata   (rf_wdata),
        .raddr_a (instr_ra),
        .rdata_a (ra_data),
        .raddr_b (instr_rb),
        .rdata_b (rb_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_alu_q <= 1'b0;
        end else begin
            out_alu_q <= out_alu;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_alu    <= 1'b0;
            operation <= OP_ADD;
            operand1  <= '0;
            operand2  <= '0;
            rd_q      <= '0;
            done      <= 1'b0;
            wb_addr   <= '0;
            wb_data   <= '0;
`ifdef ALU_CTRL_TIMEOUT_EN
            tmo_cnt   <= '0;
            err       <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state     <= ISSUE;
                        in_alu    <= 1'b1;
                        operation <= instr_op;
                        operand1  <= rb_data;
                        operand2  <= ra_data;
                        rd_q      <= instr_rd;
`ifdef ALU_CTRL_TIMEOUT_EN
                        tmo_cnt   <= '0;
`endif
                    end
                end
                ISSUE: begin
                    if (complete) begin
                        state   <= WB;
                        in_alu  <= 1'b0;
                        wb_data <= result;
                        wb_addr <= rd_q;
                        done    <= 1'b1;
                    end
`ifdef ALU_CTRL_TIMEOUT_EN
                    else if (tmo_cnt == TMO_LAST) begin
                        state  <= IDLE;
                        in_alu <= 1'b0;
                        err    <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 4'd1;
                    end
`endif
                end
                WB: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_ctrl.sv
// Scoreboard bench for alu_ctrl: stub ALU, reference register model, directed and random instructions.
module tb_alu_ctrl;
    import alu_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic        instr_op = 1'b0;
    logic [2:0]  instr_rd = '0;
    logic [2:0]  instr_ra = '0;
    logic [2:0]  instr_rb = '0;
    logic        ld_en = 1'b0;
    logic [2:0]  ld_addr = '0;
    logic [15:0] ld_data = '0;
    logic        in_alu;
    logic        operation;
    logic [15:0] operand1;
    logic [15:0] operand2;
    logic [15:0] result;
    logic        out_alu;
    logic        done;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
`ifdef ALU_CTRL_TIMEOUT_EN
    logic        err;
`endif

    int checks = 0;
    int passed = 0;
    int cyc = 0;

    logic [15:0] model_r [8];

    typedef struct {
        logic        op;
        logic [15:0] op1;
        logic [15:0] op2;
        int          acc;
    } issue_t;

    typedef struct {
        logic [2:0]  rd;
        logic [15:0] val;
        int          acc;
        int          lat;
    } wb_t;

    issue_t issueQ[$];
    wb_t    doneQ[$];
    issue_t ie;
    wb_t    wbe;
    logic   in_alu_d = 1'b0;
    logic   alu_started;
    logic   alu_stuck = 1'b0;

    alu_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_op    (instr_op),
        .instr_rd    (instr_rd),
        .instr_ra    (instr_ra),
        .instr_rb    (instr_rb),
        .ld_en       (ld_en),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .in_alu      (in_alu),
        .operation   (operation),
        .operand1    (operand1),
        .operand2    (operand2),
        .result      (result),
        .out_alu     (out_alu),
        .done        (done),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data)
`ifdef ALU_CTRL_TIMEOUT_EN
        ,
        .err         (err)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Stub ALU: drops a stale completion flag first, then raises it one cycle later with the result.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_alu     <= 1'b0;
            result      <= '0;
            alu_started <= 1'b0;
        end else if (alu_stuck) begin
            out_alu     <= 1'b0;
            alu_started <= 1'b0;
        end else if (!in_alu) begin
            alu_started <= 1'b0;
        end else if (!alu_started) begin
            alu_started <= 1'b1;
            if (out_alu) begin
                out_alu <= 1'b0;
            end else begin
                out_alu <= 1'b1;
                result  <= operation ? (operand2 - operand1) : (operand1 + operand2);
            end
        end else if (!out_alu) begin
            out_alu <= 1'b1;
            result  <= operation ? (operand2 - operand1) : (operand1 + operand2);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic reportFail(input string name);
        checks++;
        $display("[TB] FAIL %s: event occurred that the model does not allow", name);
    endtask

    // Monitor: compares operands when a request starts and the writeback report on each done pulse.
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_alu && !in_alu_d) begin
                if (issueQ.size() == 0) begin
                    reportFail("unexpected_issue");
                end else begin
                    ie = issueQ.pop_front();
                    checkOutput("operand1", operand1, ie.op1);
                    checkOutput("operand2", operand2, ie.op2);
                    checkOutput("operation", operation, ie.op);
                    checkOutput("issue_latency", cyc - ie.acc, 1);
                end
            end
            if (done) begin
                if (doneQ.size() == 0) begin
                    reportFail("unexpected_done");
                end else begin
                    wbe = doneQ.pop_front();
                    checkOutput("wb_addr", wb_addr, wbe.rd);
                    checkOutput("wb_data", wb_data, wbe.val);
                    checkOutput("done_latency", cyc - wbe.acc, wbe.lat);
                    model_r[wbe.rd] = wbe.val;
                end
            end
        end
        in_alu_d = in_alu;
    end

    task automatic preload(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        model_r[a] = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic startInstr(input logic op, input logic [2:0] rd, input logic [2:0] ra, input logic [2:0] rb);
        instr_valid = 1'b1;
        instr_op    = op;
        instr_rd    = rd;
        instr_ra    = ra;
        instr_rb    = rb;
    endtask

    task automatic finishAccept(output int waited, input bit expectDone);
        issue_t      ni;
        wb_t         nw;
        logic [15:0] a;
        logic [15:0] b;
        waited = 0;
        #1;
        while (!instr_ready && waited < 50) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!instr_ready) begin
            reportFail("accept_timeout");
            instr_valid = 1'b0;
            return;
        end
        a = model_r[instr_ra];
        b = model_r[instr_rb];
        ni.op  = instr_op;
        ni.op1 = b;
        ni.op2 = a;
        ni.acc = cyc;
        issueQ.push_back(ni);
        if (expectDone) begin
            nw.rd  = instr_rd;
            nw.val = instr_op ? (a - b) : (a + b);
            nw.acc = cyc;
            nw.lat = out_alu ? 4 : 3;
            doneQ.push_back(nw);
        end
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
    endtask

    task automatic applyStimulus(input logic op, input logic [2:0] rd, input logic [2:0] ra, input logic [2:0] rb);
        int w;
        @(negedge clk);
        startInstr(op, rd, ra, rb);
        finishAccept(w, 1'b1);
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 40; i++) begin
            if (doneQ.size() == 0) break;
            @(negedge clk);
            #1;
        end
        if (doneQ.size() != 0) begin
            reportFail("done_timeout");
            doneQ.delete();
            issueQ.delete();
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_in_alu"}, in_alu, 0);
        checkOutput({tag, "_operation"}, operation, 0);
        checkOutput({tag, "_operand1"}, operand1, 0);
        checkOutput({tag, "_operand2"}, operand2, 0);
        checkOutput({tag, "_done"}, done, 0);
        checkOutput({tag, "_wb_addr"}, wb_addr, 0);
        checkOutput({tag, "_wb_data"}, wb_data, 0);
`ifdef ALU_CTRL_TIMEOUT_EN
        checkOutput({tag, "_err"}, err, 0);
`endif
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int w;
        for (int i = 0; i < 8; i++) model_r[i] = '0;

        #12;
        checkResetOutputs("reset");
        @(negedge clk);
        #2 rst_n = 1'b1;
        #1 checkOutput("ready_after_reset", instr_ready, 1);

        // ADD with a quiet ALU, then SUB while out_alu is still high from the ADD.
        preload(3'd1, 16'd5);
        preload(3'd2, 16'd3);
        applyStimulus(OP_ADD, 3'd3, 3'd1, 3'd2);
        waitIdle();
        applyStimulus(OP_SUB, 3'd4, 3'd1, 3'd2);
        waitIdle();
        applyStimulus(OP_ADD, 3'd5, 3'd3, 3'd4);
        waitIdle();

        // Wrap-around and destination equal to a source.
        preload(3'd1, 16'd0);
        preload(3'd2, 16'd1);
        applyStimulus(OP_SUB, 3'd1, 3'd1, 3'd2);
        waitIdle();
        applyStimulus(OP_ADD, 3'd6, 3'd1, 3'd1);
        waitIdle();

        // Preload and instruction offered together, then a preload attempt during ISSUE.
        @(negedge clk);
        startInstr(OP_ADD, 3'd7, 3'd3, 3'd0);
        ld_en   = 1'b1;
        ld_addr = 3'd0;
        ld_data = 16'h1234;
        #1 checkOutput("ready_during_load", instr_ready, 0);
        model_r[0] = 16'h1234;
        @(negedge clk);
        ld_en = 1'b0;
        finishAccept(w, 1'b1);
        checkOutput("accept_after_load", w, 0);
        @(negedge clk);
        ld_en   = 1'b1;
        ld_addr = 3'd2;
        ld_data = 16'hBEEF;
        @(negedge clk);
        ld_en = 1'b0;
        waitIdle();
        applyStimulus(OP_ADD, 3'd5, 3'd2, 3'd0);
        waitIdle();

`ifdef ALU_CTRL_TIMEOUT_EN
        alu_stuck = 1'b1;
        repeat (2) @(negedge clk);
        startInstr(OP_ADD, 3'd3, 3'd1, 3'd2);
        finishAccept(w, 1'b0);
        repeat (15) @(negedge clk);
        checkOutput("tmo_in_alu_last_issue", in_alu, 1);
        checkOutput("tmo_err_before", err, 0);
        @(negedge clk);
        checkOutput("tmo_in_alu_dropped", in_alu, 0);
        checkOutput("tmo_err_set", err, 1);
        checkOutput("tmo_ready", instr_ready, 1);
        checkOutput("tmo_no_done", done, 0);
        alu_stuck = 1'b0;
        applyStimulus(OP_ADD, 3'd4, 3'd3, 3'd3);
        waitIdle();
        checkOutput("tmo_err_sticky", err, 1);
`endif

        // Reset in the middle of ISSUE aborts the instruction.
        applyStimulus(OP_SUB, 3'd2, 3'd0, 3'd5);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 checkResetOutputs("midop_reset");
        doneQ.delete();
        issueQ.delete();
        for (int i = 0; i < 8; i++) model_r[i] = '0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        #1 checkOutput("ready_after_midop_reset", instr_ready, 1);
        repeat (4) @(negedge clk);
        applyStimulus(OP_ADD, 3'd1, 3'd0, 3'd2);
        waitIdle();

        // Random instruction mix with occasional preloads and ignored ISSUE-time loads.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 9) < 3) begin
                preload(3'($urandom_range(0, 7)), 16'($urandom));
            end
            applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                          3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            if ($urandom_range(0, 9) < 3) begin
                @(negedge clk);
                ld_en   = 1'b1;
                ld_addr = 3'($urandom_range(0, 7));
                ld_data = 16'($urandom);
                @(negedge clk);
                ld_en = 1'b0;
            end
            waitIdle();
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
